// File: rtl/uart_ram_cmd.sv
// Host-driven RAM access over UART: decodes 'W' addr data / 'R' addr frames,
// drives the RAM ports and returns one response byte per frame.
module uart_ram_cmd #(
  parameter int ADDR_WIDTH     = 6,
  parameter int DATA_WIDTH     = 3,
  parameter int READ_LATENCY   = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_data_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_data_ready,
  input  logic                  tx_data_accepted,
  output logic                  write_enable,
  output logic [ADDR_WIDTH-1:0] write_address,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic [ADDR_WIDTH-1:0] read_address,
  input  logic [DATA_WIDTH-1:0] read_data,
  output logic                  busy,
  output logic                  cmd_error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int LW = $clog2(READ_LATENCY + 1);

  localparam logic [7:0] CH_WRITE = 8'h57;
  localparam logic [7:0] CH_READ  = 8'h52;
  localparam logic [7:0] CH_OK    = 8'h4B;
  localparam logic [7:0] CH_RANGE = 8'h45;
  localparam logic [7:0] CH_UNK   = 8'h3F;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_WRITE,
    S_READ_WAIT,
    S_RESP
  } state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_op_write, w_op_write_nxt;
  logic [7:0]            r_tx_data, w_tx_data_nxt;
  logic [ADDR_WIDTH-1:0] r_write_address, w_write_address_nxt;
  logic [DATA_WIDTH-1:0] r_write_data, w_write_data_nxt;
  logic [ADDR_WIDTH-1:0] r_read_address, w_read_address_nxt;
  logic [LW-1:0]         r_lat_cnt, w_lat_cnt_nxt;
  logic [TW-1:0]         r_to_cnt, w_to_cnt_nxt;
  logic                  r_cmd_error, w_cmd_error_nxt;

  // Out-of-range test: any received bit at or above the field width.
  logic w_addr_bad;
  logic w_data_bad;
  assign w_addr_bad = (rx_data >> ADDR_WIDTH) != 8'h00;
  assign w_data_bad = (rx_data >> DATA_WIDTH) != 8'h00;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_op_write      <= 1'b0;
      r_tx_data       <= '0;
      r_write_address <= '0;
      r_write_data    <= '0;
      r_read_address  <= '0;
      r_lat_cnt       <= '0;
      r_to_cnt        <= '0;
      r_cmd_error     <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_op_write      <= w_op_write_nxt;
      r_tx_data       <= w_tx_data_nxt;
      r_write_address <= w_write_address_nxt;
      r_write_data    <= w_write_data_nxt;
      r_read_address  <= w_read_address_nxt;
      r_lat_cnt       <= w_lat_cnt_nxt;
      r_to_cnt        <= w_to_cnt_nxt;
      r_cmd_error     <= w_cmd_error_nxt;
    end
  end

  always_comb begin
    w_state_nxt         = r_state;
    w_op_write_nxt      = r_op_write;
    w_tx_data_nxt       = r_tx_data;
    w_write_address_nxt = r_write_address;
    w_write_data_nxt    = r_write_data;
    w_read_address_nxt  = r_read_address;
    w_lat_cnt_nxt       = r_lat_cnt;
    w_to_cnt_nxt        = r_to_cnt;
    w_cmd_error_nxt     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (rx_data_ready) begin
          w_to_cnt_nxt = '0;
          if (rx_data == CH_WRITE) begin
            w_op_write_nxt = 1'b1;
            w_state_nxt    = S_ADDR;
          end else if (rx_data == CH_READ) begin
            w_op_write_nxt = 1'b0;
            w_state_nxt    = S_ADDR;
          end else begin
            w_tx_data_nxt   = CH_UNK;
            w_cmd_error_nxt = 1'b1;
            w_state_nxt     = S_RESP;
          end
        end
      end

      S_ADDR: begin
        if (rx_data_ready) begin
          w_to_cnt_nxt = '0;
          if (w_addr_bad) begin
            w_tx_data_nxt   = CH_RANGE;
            w_cmd_error_nxt = 1'b1;
            w_state_nxt     = S_RESP;
          end else if (r_op_write) begin
            w_write_address_nxt = rx_data[ADDR_WIDTH-1:0];
            w_state_nxt         = S_DATA;
          end else begin
            w_read_address_nxt = rx_data[ADDR_WIDTH-1:0];
            w_lat_cnt_nxt      = '0;
            w_state_nxt        = S_READ_WAIT;
          end
        end else if (r_to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          w_to_cnt_nxt = '0;
          w_state_nxt  = S_IDLE;
        end else begin
          w_to_cnt_nxt = r_to_cnt + 1'b1;
        end
      end

      S_DATA: begin
        if (rx_data_ready) begin
          w_to_cnt_nxt = '0;
          if (w_data_bad) begin
            w_tx_data_nxt   = CH_RANGE;
            w_cmd_error_nxt = 1'b1;
            w_state_nxt     = S_RESP;
          end else begin
            w_write_data_nxt = rx_data[DATA_WIDTH-1:0];
            w_state_nxt      = S_WRITE;
          end
        end else if (r_to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          w_to_cnt_nxt = '0;
          w_state_nxt  = S_IDLE;
        end else begin
          w_to_cnt_nxt = r_to_cnt + 1'b1;
        end
      end

      S_WRITE: begin
        w_tx_data_nxt = CH_OK;
        w_state_nxt   = S_RESP;
      end

      // read_data is sampled in the last of READ_LATENCY wait cycles.
      S_READ_WAIT: begin
        if (r_lat_cnt == LW'(READ_LATENCY - 1)) begin
          w_tx_data_nxt = 8'(read_data);
          w_lat_cnt_nxt = '0;
          w_state_nxt   = S_RESP;
        end else begin
          w_lat_cnt_nxt = r_lat_cnt + 1'b1;
        end
      end

      S_RESP: begin
        if (tx_data_accepted) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign tx_data       = r_tx_data;
  assign tx_data_ready = (r_state == S_RESP);
  assign write_enable  = (r_state == S_WRITE);
  assign write_address = r_write_address;
  assign write_data    = r_write_data;
  assign read_address  = r_read_address;
  assign busy          = (r_state != S_IDLE);
  assign cmd_error     = r_cmd_error;

endmodule

// File: tb/tb_uart_ram_cmd.sv
// Directed bench for uart_ram_cmd: cycle-by-cycle vector table plus
// hand-written timeout and mid-frame reset sequences against a RAM model.
module tb_uart_ram_cmd;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_data_ready;
  logic [7:0] tx_data;
  logic       tx_data_ready;
  logic       tx_data_accepted;
  logic       write_enable;
  logic [5:0] write_address;
  logic [2:0] write_data;
  logic [5:0] read_address;
  logic [2:0] read_data;
  logic       busy;
  logic       cmd_error;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  uart_ram_cmd #(
    .ADDR_WIDTH    (6),
    .DATA_WIDTH    (3),
    .READ_LATENCY  (2),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .rx_data         (rx_data),
    .rx_data_ready   (rx_data_ready),
    .tx_data         (tx_data),
    .tx_data_ready   (tx_data_ready),
    .tx_data_accepted(tx_data_accepted),
    .write_enable    (write_enable),
    .write_address   (write_address),
    .write_data      (write_data),
    .read_address    (read_address),
    .read_data       (read_data),
    .busy            (busy),
    .cmd_error       (cmd_error)
  );

  // RAM model: one register stage, so data for an address set at a clock
  // edge is readable during the second cycle after it (latency 2).
  logic [2:0] mem [64];
  logic       mem_ready = 1'b0;
  logic [2:0] ram_q = 3'd0;
  assign read_data = ram_q;

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 64; i++) mem[i] <= 3'(i) ^ 3'b010;
      mem_ready <= 1'b1;
    end else if (write_enable) begin
      mem[write_address] <= write_data;
    end
    ram_q <= mem[read_address];
  end

  // {busy, err, we, txr, tx[7:0], wa[5:0], wd[2:0], ra[5:0]}
  function automatic logic [26:0] mk(input logic b, input logic e, input logic we,
                                     input logic txr, input logic [7:0] tx,
                                     input logic [5:0] wa, input logic [2:0] wd,
                                     input logic [5:0] ra);
    return {b, e, we, txr, tx, wa, wd, ra};
  endfunction

  function automatic logic [26:0] ov();
    return {busy, cmd_error, write_enable, tx_data_ready, tx_data,
            write_address, write_data, read_address};
  endfunction

  typedef struct {
    logic        r;
    logic        v;
    logic [7:0]  b;
    logic        a;
    logic [26:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic v, input logic [7:0] b, input logic a,
                     input logic [26:0] exp);
    vec_t t;
    t.r = r; t.v = v; t.b = b; t.a = a; t.exp = exp;
    vecs.push_back(t);
  endtask

  task automatic step(input logic r, input logic v, input logic [7:0] b, input logic a);
    rst              = r;
    rx_data_ready    = v;
    rx_data          = v ? b : 8'h00;
    tx_data_accepted = a;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic stray;

  initial begin
    rst = 1'b1; rx_data = 8'h00; rx_data_ready = 1'b0; tx_data_accepted = 1'b0;

    // Write W,05,06 then hold acceptance off for 10 cycles.
    add(1, 0, 8'h00, 0, mk(0,0,0,0,8'h00,6'h00,3'd0,6'h00));
    add(0, 1, 8'h57, 0, mk(1,0,0,0,8'h00,6'h00,3'd0,6'h00));
    add(0, 1, 8'h05, 0, mk(1,0,0,0,8'h00,6'h05,3'd0,6'h00));
    add(0, 1, 8'h06, 0, mk(1,0,1,0,8'h00,6'h05,3'd6,6'h00));
    for (int i = 0; i < 11; i++)
      add(0, 0, 8'h00, 0, mk(1,0,0,1,8'h4B,6'h05,3'd6,6'h00));
    add(0, 0, 8'h00, 1, mk(0,0,0,0,8'h4B,6'h05,3'd6,6'h00));
    // Read R,3F: response 3 cycles after the address strobe.
    add(0, 1, 8'h52, 0, mk(1,0,0,0,8'h4B,6'h05,3'd6,6'h00));
    add(0, 1, 8'h3F, 0, mk(1,0,0,0,8'h4B,6'h05,3'd6,6'h3F));
    add(0, 0, 8'h00, 0, mk(1,0,0,0,8'h4B,6'h05,3'd6,6'h3F));
    add(0, 0, 8'h00, 0, mk(1,0,0,1,8'h05,6'h05,3'd6,6'h3F));
    add(0, 0, 8'h00, 1, mk(0,0,0,0,8'h05,6'h05,3'd6,6'h3F));
    // R,40: address out of range.
    add(0, 1, 8'h52, 0, mk(1,0,0,0,8'h05,6'h05,3'd6,6'h3F));
    add(0, 1, 8'h40, 0, mk(1,1,0,1,8'h45,6'h05,3'd6,6'h3F));
    add(0, 0, 8'h00, 0, mk(1,0,0,1,8'h45,6'h05,3'd6,6'h3F));
    add(0, 0, 8'h00, 1, mk(0,0,0,0,8'h45,6'h05,3'd6,6'h3F));
    // W,00,08: data out of range, no write.
    add(0, 1, 8'h57, 0, mk(1,0,0,0,8'h45,6'h05,3'd6,6'h3F));
    add(0, 1, 8'h00, 0, mk(1,0,0,0,8'h45,6'h00,3'd6,6'h3F));
    add(0, 1, 8'h08, 0, mk(1,1,0,1,8'h45,6'h00,3'd6,6'h3F));
    add(0, 0, 8'h00, 1, mk(0,0,0,0,8'h45,6'h00,3'd6,6'h3F));
    // Unknown command, byte during RESP dropped, byte with accept dropped.
    add(0, 1, 8'h00, 0, mk(1,1,0,1,8'h3F,6'h00,3'd6,6'h3F));
    add(0, 1, 8'h57, 0, mk(1,0,0,1,8'h3F,6'h00,3'd6,6'h3F));
    add(0, 1, 8'h52, 1, mk(0,0,0,0,8'h3F,6'h00,3'd6,6'h3F));
    // W,02,07 completes normally, then read it back.
    add(0, 1, 8'h57, 0, mk(1,0,0,0,8'h3F,6'h00,3'd6,6'h3F));
    add(0, 1, 8'h02, 0, mk(1,0,0,0,8'h3F,6'h02,3'd6,6'h3F));
    add(0, 1, 8'h07, 0, mk(1,0,1,0,8'h3F,6'h02,3'd7,6'h3F));
    add(0, 0, 8'h00, 0, mk(1,0,0,1,8'h4B,6'h02,3'd7,6'h3F));
    add(0, 0, 8'h00, 1, mk(0,0,0,0,8'h4B,6'h02,3'd7,6'h3F));
    add(0, 1, 8'h52, 0, mk(1,0,0,0,8'h4B,6'h02,3'd7,6'h3F));
    add(0, 1, 8'h02, 0, mk(1,0,0,0,8'h4B,6'h02,3'd7,6'h02));
    add(0, 0, 8'h00, 0, mk(1,0,0,0,8'h4B,6'h02,3'd7,6'h02));
    add(0, 0, 8'h00, 0, mk(1,0,0,1,8'h07,6'h02,3'd7,6'h02));
    add(0, 0, 8'h00, 1, mk(0,0,0,0,8'h07,6'h02,3'd7,6'h02));
    // Read back mem[5] written by the first frame.
    add(0, 1, 8'h52, 0, mk(1,0,0,0,8'h07,6'h02,3'd7,6'h02));
    add(0, 1, 8'h05, 0, mk(1,0,0,0,8'h07,6'h02,3'd7,6'h05));
    add(0, 0, 8'h00, 0, mk(1,0,0,0,8'h07,6'h02,3'd7,6'h05));
    add(0, 0, 8'h00, 0, mk(1,0,0,1,8'h06,6'h02,3'd7,6'h05));
    add(0, 0, 8'h00, 1, mk(0,0,0,0,8'h06,6'h02,3'd7,6'h05));
    add(0, 0, 8'h00, 1, mk(0,0,0,0,8'h06,6'h02,3'd7,6'h05));

    step(1, 0, 8'h00, 0);
    step(1, 0, 8'h00, 0);
    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].v, vecs[i].b, vecs[i].a);
      check($sformatf("row%0d", i), 32'(ov()), 32'(vecs[i].exp));
    end

    // Timeout in DATA after 100 idle cycles: no response, no error, no write.
    step(0, 1, 8'h57, 0);
    step(0, 1, 8'h01, 0);
    stray = 1'b0;
    for (int i = 0; i < 99; i++) begin
      step(0, 0, 8'h00, 0);
      if (tx_data_ready || cmd_error || write_enable) stray = 1'b1;
    end
    check("timeout_busy_99", 32'(busy), 32'd1);
    step(0, 0, 8'h00, 0);
    if (tx_data_ready || cmd_error || write_enable) stray = 1'b1;
    check("timeout_idle_100", 32'(busy), 32'd0);
    check("timeout_no_tx", 32'(stray), 32'd0);
    step(0, 1, 8'h52, 0);
    step(0, 1, 8'h01, 0);
    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 0);
    check("timeout_read_mem1", 32'({tx_data_ready, tx_data}), 32'h103);
    step(0, 0, 8'h00, 1);

    // Reset during READ_WAIT, then a normal read.
    step(0, 1, 8'h52, 0);
    step(0, 1, 8'h3F, 0);
    step(1, 0, 8'h00, 0);
    check("rst_readwait_out", 32'(ov()), 32'd0);
    step(0, 1, 8'h52, 0);
    step(0, 1, 8'h05, 0);
    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 0);
    check("rst_readwait_next", 32'({tx_data_ready, tx_data}), 32'h106);
    step(0, 0, 8'h00, 1);

    // Reset during RESP of W,03,04; the write itself already happened.
    step(0, 1, 8'h57, 0);
    step(0, 1, 8'h03, 0);
    step(0, 1, 8'h04, 0);
    step(0, 0, 8'h00, 0);
    check("rst_resp_pre", 32'({tx_data_ready, tx_data}), 32'h14B);
    step(1, 0, 8'h00, 0);
    check("rst_resp_out", 32'(ov()), 32'd0);
    step(0, 1, 8'h52, 0);
    step(0, 1, 8'h03, 0);
    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 0);
    check("rst_resp_next", 32'({tx_data_ready, tx_data}), 32'h104);
    step(0, 0, 8'h00, 1);
    check("final_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_ram_cmd.md
# uart_ram_cmd

UART command responder that lets a host read and write a LUT-RAM under test over the serial link. It consumes received bytes from the `UART` receive side (`rx_data` / `rx_data_ready`), decodes write and read command frames, and drives the RAM write and read ports. It returns one response byte per frame through the `UART` transmit handshake. It sits beside `RAM_TEST` in the DRAM test tops as a host-driven access path, mirroring the report stream produced by `ERROR_OUTPUT_LOGIC`.

## Interface
- `ADDR_WIDTH`, 6: RAM address width; must be ≤ 8.
- `DATA_WIDTH`, 3: RAM data width; must be ≤ 8.
- `READ_LATENCY`, 2: cycles from `read_address` change to valid `read_data`; must be ≥ 1.
- `TIMEOUT_CYCLES`, 65535: maximum idle cycles allowed between bytes of one frame.
- `clk`  in  1  single clock for all logic.
- `rst`  in  1  synchronous, active-high reset.
- `rx_data`  in  8  received byte; valid only while `rx_data_ready` is high.
- `rx_data_ready`  in  1  one-cycle strobe, one per received byte.
- `tx_data`  out  8  response byte.
- `tx_data_ready`  out  1  response valid; held high until accepted.
- `tx_data_accepted`  in  1  one-cycle pulse from the UART taking `tx_data`.
- `write_enable`  out  1  one-cycle RAM write strobe.
- `write_address`  out  ADDR_WIDTH  RAM write address.
- `write_data`  out  DATA_WIDTH  RAM write data.
- `read_address`  out  ADDR_WIDTH  RAM read address.
- `read_data`  in  DATA_WIDTH  RAM read data, valid `READ_LATENCY` cycles after `read_address` changes.
- `busy`  out  1  high in every state except IDLE.
- `cmd_error`  out  1  one-cycle pulse on any rejected frame.

## Operation
- Frame formats:
  - Write frame: `0x57 ('W')`, address byte, data byte.
  - Read frame: `0x52 ('R')`, address byte.
- States: IDLE, ADDR, DATA, WRITE, READ_WAIT, RESP.
- IDLE:
  - Byte `0x57` goes to ADDR with the op latched as write.
  - Byte `0x52` goes to ADDR with the op latched as read.
  - Any other byte loads `tx_data=0x3F ('?')`, pulses `cmd_error`, and goes to RESP.
- ADDR, on a byte:
  - If any bit at or above ADDR_WIDTH is set: load `tx_data=0x45 ('E')`, pulse `cmd_error`, go to RESP. No RAM access occurs.
  - Otherwise, for a write op: latch `write_address` and go to DATA.
  - Otherwise, for a read op: latch `read_address` and go to READ_WAIT.
- DATA, on a byte:
  - Same rule with DATA_WIDTH: any bit at or above DATA_WIDTH set → `'E'`, `cmd_error` pulse, RESP, no write.
  - Otherwise latch `write_data` and go to WRITE.
- WRITE: assert `write_enable` for exactly this one cycle, load `tx_data=0x4B ('K')`, go to RESP.
- READ_WAIT:
  - Count `READ_LATENCY` cycles.
  - On the last count, capture `tx_data = {zero pad, read_data}` and go to RESP.
- RESP: hold `tx_data_ready=1` and `tx_data` stable until `tx_data_accepted`, then go to IDLE.
- Timeout:
  - Applies in ADDR and DATA only.
  - The counter resets on each accepted byte.
  - If `TIMEOUT_CYCLES` cycles pass without a byte: return to IDLE, send no response, no `cmd_error`, no RAM access.
- Bytes arriving in WRITE, READ_WAIT or RESP are dropped silently.
- `tx_data_accepted` outside RESP is ignored.
- `read_address` and `write_address` / `write_data` keep their last values between frames.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0.
- `rst` mid-frame aborts the frame; `tx_data_ready` and `write_enable` are low from the next edge.
- Write frame, data byte strobe in cycle t:
  - `write_data` valid and `write_enable=1` in cycle t+1.
  - `tx_data_ready=1` with `'K'` from cycle t+2.
- Read frame, address strobe in cycle t:
  - `read_address` valid from cycle t+1.
  - `read_data` sampled at the end of cycle t+READ_LATENCY.
  - `tx_data_ready=1` from cycle t+READ_LATENCY+1.
- Rejected byte in cycle t: `cmd_error=1` and `tx_data_ready=1` in cycle t+1.
- `tx_data_accepted` in cycle t: `tx_data_ready=0` and state IDLE in cycle t+1. An `rx_data_ready` in cycle t is dropped; a byte in cycle t+1 is decoded.
- Byte throughput: one per cycle; back-to-back strobes are legal.

## Test plan
- After reset: send `W,0x05,0x06`. Expect exactly one `write_enable` pulse with `write_address=5`, `write_data=6`, then `tx_data=0x4B`. Hold `tx_data_accepted` off for 10 cycles; `tx_data_ready` must stay high with `tx_data` stable.
- Bench RAM model with 2-cycle latency, `mem[0x3F]=3'b101`: send `R,0x3F`. Expect `read_address=0x3F`, then `tx_data=0x05` exactly 3 cycles after the address strobe.
- Send `R,0x40` (address bit 6 set). Expect a `cmd_error` pulse, `tx_data=0x45`, and no change on `read_address`. Then send `W,0x00,0x08` (data bit 3 set): expect `'E'` and no `write_enable`.
- Send byte `0x00` in IDLE. Expect `'?'`. A byte strobed during RESP is dropped; a `W` frame sent after acceptance completes normally.
- With `TIMEOUT_CYCLES=100`: send `W,0x01`, then wait 100 cycles. Expect return to IDLE and no tx. Next `R,0x01` must return `mem[1]`.
- Assert `rst` in READ_WAIT and again in RESP. Expect all outputs 0 on the next cycle, and the following frame to decode correctly.
